// File: rtl/fib_lfsr_axi_slave.sv
// AXI4-Lite register slave around a 32-bit Fibonacci LFSR with programmable seed and taps.
// Map: 0x0 CTRL (RUN / STEP / LOAD), 0x4 SEED, 0x8 TAPS, 0xC STATE (read-only).
module fib_lfsr_axi_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [31:0]                     lfsr_out,
    output logic                            lfsr_adv
);

    localparam logic [1:0]  REG_CTRL  = 2'd0;
    localparam logic [1:0]  REG_SEED  = 2'd1;
    localparam logic [1:0]  REG_TAPS  = 2'd2;
    localparam logic [1:0]  REG_STATE = 2'd3;
    localparam logic [31:0] SEED_RST  = 32'h0000_0001;
    localparam logic [31:0] TAPS_RST  = 32'h8020_0003;
    localparam logic [31:0] STATE_RST = 32'h0000_0001;

    logic        run_q;
    logic [31:0] seed_q;
    logic [31:0] taps_q;
    logic [31:0] state_q;
    logic [31:0] state_d;
    logic        adv_q;
    logic        bvalid_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [31:0] rd_mux;

    logic        wr_accept;
    logic        rd_accept;
    logic [1:0]  wr_sel;
    logic [1:0]  rd_sel;
    logic        ctrl_wr;
    logic        do_load;
    logic        do_adv;
    logic        fb;
    logic        unused_inputs;

    // NOTE: READY is combinational and gated by the reset input so that an asserted
    // reset drops it in the same instant as the registered VALIDs.
    assign wr_accept = S_AXI_ARESETN & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
    assign rd_accept = S_AXI_ARESETN & S_AXI_ARVALID & ~rvalid_q;
    assign wr_sel    = S_AXI_AWADDR[3:2];
    assign rd_sel    = S_AXI_ARADDR[3:2];

    assign ctrl_wr = wr_accept && (wr_sel == REG_CTRL) && S_AXI_WSTRB[0];
    assign do_load = ctrl_wr & S_AXI_WDATA[2];
    assign do_adv  = run_q | (ctrl_wr & S_AXI_WDATA[1]);
    assign fb      = ^(state_q & taps_q);

    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    // LOAD beats an advance; a zero seed loads 1 so the register can never lock up.
    always_comb begin
        state_d = state_q;
        if (do_load) begin
            state_d = (seed_q == 32'h0) ? 32'h0000_0001 : seed_q;
        end else if (do_adv) begin
            state_d = {state_q[30:0], fb};
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register samples
    // the pre-edge values, which is what makes LOAD see the old SEED.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            run_q    <= 1'b0;
            seed_q   <= SEED_RST;
            taps_q   <= TAPS_RST;
            state_q  <= STATE_RST;
            adv_q    <= 1'b0;
            bvalid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            adv_q   <= do_load | do_adv;
            if (wr_accept) begin
                bvalid_q <= 1'b1;
                case (wr_sel)
                    REG_CTRL: if (S_AXI_WSTRB[0]) run_q <= S_AXI_WDATA[0];
                    REG_SEED: seed_q <= apply_strb(seed_q, S_AXI_WDATA, S_AXI_WSTRB);
                    REG_TAPS: taps_q <= apply_strb(taps_q, S_AXI_WDATA, S_AXI_WSTRB);
                    default:  ;
                endcase
            end else if (S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_mux = 32'h0;
        case (rd_sel)
            REG_CTRL:  rd_mux = {31'h0, run_q};
            REG_SEED:  rd_mux = seed_q;
            REG_TAPS:  rd_mux = taps_q;
            REG_STATE: rd_mux = state_q;
            default:   rd_mux = 32'h0;
        endcase
    end

    // RDATA is frozen from capture until the RVALID handshake completes.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
        end else if (rd_accept) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_mux;
        end else if (S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    assign S_AXI_AWREADY = wr_accept;
    assign S_AXI_WREADY  = wr_accept;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = rd_accept;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;
    assign lfsr_out      = state_q;
    assign lfsr_adv      = adv_q;

endmodule
